universal_shift_register: RTL and testbench
===========================================

UNIVERSAL_SHIFT_REGISTER -- requirements
Module: universal_shift_register

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits; SHALL be at least 2.
REQ-002 Parameter STEP_W, default 3, width of per-cycle shift amount.
REQ-003 Parameter CNT_W, default 4, width of repeat count.
REQ-004 clk  input  1  rising-edge clock; single clock domain.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 load  input  1  parallel load request.
REQ-007 load_value  input  WIDTH  parallel load data.
REQ-008 start  input  1  begin multi-cycle shift operation.
REQ-009 dir  input  1  0 = left (toward MSB), 1 = right.
REQ-010 mode  input  2  00 logical, 01 arithmetic, 10 rotate, 11 serial fill.
REQ-011 step  input  STEP_W  bit positions shifted per cycle.
REQ-012 count  input  CNT_W  number of shift cycles.
REQ-013 si  input  1  serial fill bit; used only in mode 11.
REQ-014 PO  output  WIDTH  register contents, registered.
REQ-015 so  output  1  last bit shifted out, registered.
REQ-016 busy  output  1  high while the operation is in RUN.
REQ-017 done  output  1  one-cycle completion pulse, registered.

Function
REQ-018 The block SHALL use a two-state FSM: IDLE and RUN.
REQ-019 IDLE, load=1: PO <= load_value on the next edge; load SHALL take priority over start.
REQ-020 IDLE, start=1, count>0, load=0: latch dir, mode, step and si; set remaining = count; enter RUN.
REQ-021 IDLE, start=1, count=0, load=0: PO SHALL NOT change, state stays IDLE, and done SHALL pulse on the next cycle.
REQ-022 RUN: each edge SHALL apply one shift by the latched step, using the latched mode, dir and si, and decrement remaining.
REQ-023 RUN, remaining=1: after the final shift, return to IDLE with done=1 for exactly one cycle as busy falls.
REQ-024 A count of N SHALL update PO on N consecutive edges after the start edge, with busy high for exactly N cycles.
REQ-025 Changes to dir, mode, step, count or si during RUN SHALL have no effect.
REQ-026 start during RUN SHALL be ignored.
REQ-027 load during RUN SHALL abort the operation: PO <= load_value, go to IDLE, no done pulse.
REQ-028 Logical mode: vacated bits SHALL be filled with 0.
REQ-029 Arithmetic mode, right: vacated bits SHALL be filled with the pre-shift MSB; left SHALL behave identically to logical.
REQ-030 Rotate mode: bits leaving one end SHALL enter the other end; the effective amount SHALL be step mod WIDTH.
REQ-031 Fill mode: vacated bits SHALL be filled with the latched si.
REQ-032 step=0: PO SHALL hold, but the cycle still counts against remaining.
REQ-033 step>=WIDTH: result SHALL be all-zero (logical), all pre-shift MSB (arithmetic right), all si (fill), or modulo rotate (rotate).
REQ-034 so update rule (all modes, rotate included):
- left: so <= pre-shift PO[WIDTH-step];
- right: so <= pre-shift PO[step-1];
- applies only when 1<=step<=WIDTH; otherwise so holds.
REQ-035 busy SHALL be a direct decode of state==RUN.

Reset
REQ-036 rst=1 SHALL asynchronously force PO=0, so=0, busy=0, done=0, remaining=0 and state=IDLE, including mid-RUN.
REQ-037 After rst is released, the first edge SHALL behave as IDLE, with no spurious done.

Verification (WIDTH=8, STEP_W=3, CNT_W=4)
REQ-038 load 8'hA5; start dir=0 mode=00 step=1 count=3 -> PO 8'h4A, 8'h94, 8'h28 on successive edges; so 1,0,1; busy 3 cycles; done one pulse.
REQ-039 load 8'h90; start dir=1 mode=01 step=2 count=1 -> PO 8'hE4, so 0, done pulse.
REQ-040 load 8'h81; start dir=1 mode=10 step=3 count=2 -> PO 8'h30 then 8'h06; so 0,0.
REQ-041 PO=0; start dir=1 mode=11 si=1 step=4 count=1 -> PO 8'hF0; then start dir=0 mode=11 si=0 step=4 count=1 -> PO 8'h00.
REQ-042 count=0 start -> PO unchanged, busy never high, done one pulse; load 8'h3C asserted during a RUN with count=5 -> PO 8'h3C, IDLE, no done.
REQ-043 rst asserted mid-RUN between edges -> PO, so, busy and done all 0 immediately; next start behaves normally.

Source files
------------

// File: rtl/universal_shift_register.sv
// Universal shift register: parallel load plus multi-cycle logical, arithmetic, rotate or
// serial-fill shifts by a programmable step, repeated a programmable number of cycles.
module universal_shift_register #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STEP_W = 3,
  parameter int unsigned CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_value,
  input  logic              start,
  input  logic              dir,
  input  logic [1:0]        mode,
  input  logic [STEP_W-1:0] step,
  input  logic [CNT_W-1:0]  count,
  input  logic              si,
  output logic [WIDTH-1:0]  PO,
  output logic              so,
  output logic              busy,
  output logic              done
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  localparam logic [1:0] ModeArith  = 2'b01;
  localparam logic [1:0] ModeRotate = 2'b10;
  localparam logic [1:0] ModeFill   = 2'b11;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   po_q, po_d;
  logic               so_q, so_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic               dir_q, dir_d;
  logic [1:0]         mode_q, mode_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic               si_q, si_d;
  logic [WIDTH-1:0]   so_tap;
  int unsigned        step_n;

  // Shifting an all-ones word by the same amount yields the vacated-bit mask, which also
  // saturates to all-ones for steps >= WIDTH.
  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0]  v,
                                                  input logic [STEP_W-1:0] s,
                                                  input logic              d,
                                                  input logic [1:0]        m,
                                                  input logic              f);
    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] res;
    logic             fb;
    int unsigned      r;
    ones = '1;
    r    = 32'(s) % WIDTH;
    fb   = 1'b0;
    if (m == ModeRotate) begin
      if (d) res = (v >> r) | (v << (WIDTH - r));
      else   res = (v << r) | (v >> (WIDTH - r));
    end else begin
      if (m == ModeFill)             fb = f;
      else if (m == ModeArith && d)  fb = v[WIDTH-1];
      if (d) res = (v >> s) | (fb ? ~(ones >> s) : '0);
      else   res = (v << s) | (fb ? ~(ones << s) : '0);
    end
    return res;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (!load && start && count != '0) state_d = StRun;
      StRun:  if (load || rem_q == CNT_W'(1))    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q == StRun);
  end

  always_comb begin
    po_d   = po_q;
    so_d   = so_q;
    done_d = 1'b0;
    rem_d  = rem_q;
    dir_d  = dir_q;
    mode_d = mode_q;
    step_d = step_q;
    si_d   = si_q;
    so_tap = '0;
    step_n = 32'(step_q);
    unique case (state_q)
      StIdle: begin
        if (load) begin
          po_d = load_value;
        end else if (start) begin
          if (count != '0) begin
            dir_d  = dir;
            mode_d = mode;
            step_d = step;
            si_d   = si;
            rem_d  = count;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (load) begin
          po_d  = load_value;
          rem_d = '0;
        end else begin
          po_d  = shift_word(po_q, step_q, dir_q, mode_q, si_q);
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) done_d = 1'b1;
          // so captures the last bit to leave the word; outside 1..WIDTH it holds.
          if (step_n != 0 && step_n <= WIDTH) begin
            so_tap = dir_q ? (po_q >> (step_n - 1)) : (po_q >> (WIDTH - step_n));
            so_d   = so_tap[0];
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      po_q   <= '0;
      so_q   <= 1'b0;
      done_q <= 1'b0;
      rem_q  <= '0;
      dir_q  <= 1'b0;
      mode_q <= '0;
      step_q <= '0;
      si_q   <= 1'b0;
    end else begin
      po_q   <= po_d;
      so_q   <= so_d;
      done_q <= done_d;
      rem_q  <= rem_d;
      dir_q  <= dir_d;
      mode_q <= mode_d;
      step_q <= step_d;
      si_q   <= si_d;
    end
  end

  assign PO   = po_q;
  assign so   = so_q;
  assign done = done_q;

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed bench for universal_shift_register: single-shift vector table plus hand-written
// multi-cycle, count-zero, abort and mid-run reset sequences.
module tb_universal_shift_register;

  logic       clk;
  logic       rst;
  logic       load;
  logic [7:0] load_value;
  logic       start;
  logic       dir;
  logic [1:0] mode;
  logic [2:0] step;
  logic [3:0] count;
  logic       si;
  logic [7:0] PO;
  logic       so;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] lv;
    logic       d;
    logic [1:0] m;
    logic [2:0] s;
    logic       f;
    logic [7:0] exp_po;
    logic       exp_so;
  } vec_t;

  vec_t vecs [13];
  logic [7:0] seq_po [3];
  logic       seq_so [3];

  universal_shift_register #(
    .WIDTH (8),
    .STEP_W(3),
    .CNT_W (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_value(load_value),
    .start     (start),
    .dir       (dir),
    .mode      (mode),
    .step      (step),
    .count     (count),
    .si        (si),
    .PO        (PO),
    .so        (so),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_load(input logic [7:0] v);
    load = 1'b1;
    load_value = v;
    tick();
    load = 1'b0;
  endtask

  task automatic do_start(input logic d, input logic [1:0] m, input logic [2:0] s,
                          input logic f, input logic [3:0] c);
    dir = d;
    mode = m;
    step = s;
    si = f;
    count = c;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{8'hA5, 1'b0, 2'b00, 3'd1, 1'b0, 8'h4A, 1'b1};
    vecs[1]  = '{8'h90, 1'b1, 2'b01, 3'd2, 1'b0, 8'hE4, 1'b0};
    vecs[2]  = '{8'h81, 1'b1, 2'b10, 3'd3, 1'b0, 8'h30, 1'b0};
    vecs[3]  = '{8'h00, 1'b1, 2'b11, 3'd4, 1'b1, 8'hF0, 1'b0};
    vecs[4]  = '{8'hF0, 1'b0, 2'b11, 3'd4, 1'b0, 8'h00, 1'b1};
    vecs[5]  = '{8'h96, 1'b1, 2'b00, 3'd3, 1'b0, 8'h12, 1'b1};
    vecs[6]  = '{8'hC3, 1'b0, 2'b01, 3'd2, 1'b0, 8'h0C, 1'b1};
    vecs[7]  = '{8'h81, 1'b0, 2'b10, 3'd1, 1'b0, 8'h03, 1'b1};
    vecs[8]  = '{8'h5A, 1'b0, 2'b00, 3'd0, 1'b0, 8'h5A, 1'b1}; // step 0: PO and so hold
    vecs[9]  = '{8'h01, 1'b0, 2'b11, 3'd7, 1'b1, 8'hFF, 1'b0};
    vecs[10] = '{8'h7F, 1'b1, 2'b01, 3'd7, 1'b0, 8'h00, 1'b1};
    vecs[11] = '{8'h80, 1'b1, 2'b01, 3'd7, 1'b0, 8'hFF, 1'b0};
    vecs[12] = '{8'h6C, 1'b1, 2'b10, 3'd7, 1'b0, 8'hD8, 1'b1};
    seq_po[0] = 8'h4A; seq_po[1] = 8'h94; seq_po[2] = 8'h28;
    seq_so[0] = 1'b1;  seq_so[1] = 1'b0;  seq_so[2] = 1'b1;

    rst = 1'b1; load = 1'b0; load_value = '0; start = 1'b0;
    dir = 1'b0; mode = '0; step = '0; count = '0; si = 1'b0;
    tick();
    tick();
    check("reset PO", 32'(PO), 32'h0);
    check("reset so", 32'(so), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check("reset done", 32'(done), 32'h0);
    rst = 1'b0;
    tick();
    check("post-reset done", 32'(done), 32'h0);
    check("post-reset busy", 32'(busy), 32'h0);

    for (int i = 0; i < 13; i++) begin
      do_load(vecs[i].lv);
      do_start(vecs[i].d, vecs[i].m, vecs[i].s, vecs[i].f, 4'd1);
      check($sformatf("v%0d busy", i), 32'(busy), 32'h1);
      tick();
      check($sformatf("v%0d PO", i), 32'(PO), 32'(vecs[i].exp_po));
      check($sformatf("v%0d so", i), 32'(so), 32'(vecs[i].exp_so));
      check($sformatf("v%0d done", i), 32'(done), 32'h1);
      tick();
      check($sformatf("v%0d done clear", i), 32'(done), 32'h0);
    end

    // Three-cycle logical left; inputs scrambled and start held during RUN.
    do_load(8'hA5);
    dir = 1'b0; mode = 2'b00; step = 3'd1; si = 1'b0; count = 4'd3; start = 1'b1;
    tick();
    dir = 1'b1; mode = 2'b11; step = 3'd7; si = 1'b1; count = 4'd0;
    check("seq start busy", 32'(busy), 32'h1);
    check("seq start PO", 32'(PO), 32'hA5);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("seq%0d PO", k), 32'(PO), 32'(seq_po[k]));
      check($sformatf("seq%0d so", k), 32'(so), 32'(seq_so[k]));
      check($sformatf("seq%0d busy", k), 32'(busy), (k < 2) ? 32'h1 : 32'h0);
      check($sformatf("seq%0d done", k), 32'(done), (k == 2) ? 32'h1 : 32'h0);
    end
    start = 1'b0;
    tick();
    check("seq end done", 32'(done), 32'h0);
    check("seq end PO", 32'(PO), 32'h28);

    // count = 0: no change, no busy, one done pulse.
    do_load(8'h77);
    do_start(1'b0, 2'b00, 3'd1, 1'b0, 4'd0);
    check("cnt0 PO", 32'(PO), 32'h77);
    check("cnt0 busy", 32'(busy), 32'h0);
    check("cnt0 done", 32'(done), 32'h1);
    tick();
    check("cnt0 done clear", 32'(done), 32'h0);
    check("cnt0 busy after", 32'(busy), 32'h0);

    // Load during RUN aborts without done.
    do_load(8'hA5);
    do_start(1'b0, 2'b00, 3'd1, 1'b0, 4'd5);
    tick();
    check("abort mid PO", 32'(PO), 32'h4A);
    do_load(8'h3C);
    check("abort PO", 32'(PO), 32'h3C);
    check("abort busy", 32'(busy), 32'h0);
    check("abort done", 32'(done), 32'h0);
    tick();
    check("abort done later", 32'(done), 32'h0);
    check("abort PO later", 32'(PO), 32'h3C);

    // Asynchronous reset between edges mid-RUN.
    do_load(8'hA5);
    do_start(1'b0, 2'b00, 3'd1, 1'b0, 4'd5);
    tick();
    check("rst pre so", 32'(so), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("rst async PO", 32'(PO), 32'h0);
    check("rst async so", 32'(so), 32'h0);
    check("rst async busy", 32'(busy), 32'h0);
    check("rst async done", 32'(done), 32'h0);
    tick();
    rst = 1'b0;
    tick();
    check("rst release done", 32'(done), 32'h0);
    check("rst release busy", 32'(busy), 32'h0);
    do_load(8'h90);
    do_start(1'b1, 2'b01, 3'd2, 1'b0, 4'd1);
    check("rst next busy", 32'(busy), 32'h1);
    tick();
    check("rst next PO", 32'(PO), 32'hE4);
    check("rst next done", 32'(done), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
